// File: rtl/hack_mem_ctrl.sv
// rtl/hack_mem_ctrl.sv - Hack data-memory map with keyboard latch, fault flag and screen mirror FIFO
// Optional fault counter enabled by defining HACK_MEM_FAULT_CNT_EN.
module hack_mem_ctrl #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 15,
   parameter int                RAM_AW   = 14,
   parameter int                SCR_AW   = 13,
   parameter logic [ADDR_W-1:0] KBD_ADDR = 15'h6000,
   parameter int                FIFO_AW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_i,
   input  logic [ADDR_W-1:0] address_i,
   input  logic              load_i,
   output logic [DATA_W-1:0] out_o,
   output logic [1:0]        region_o,
   output logic              fault_o,
   input  logic              fault_clr_i,
   input  logic [DATA_W-1:0] kbd_code_i,
   input  logic              kbd_strobe_i,
   input  logic              kbd_release_i,
   output logic              scr_valid_o,
   input  logic              scr_ready_i,
   output logic [SCR_AW-1:0] scr_addr_o,
   output logic [DATA_W-1:0] scr_data_o,
   output logic              scr_ovf_o,
   output logic [7:0]        fault_cnt_o
);

   localparam logic [1:0] REG_RAM = 2'd0;
   localparam logic [1:0] REG_SCR = 2'd1;
   localparam logic [1:0] REG_KBD = 2'd2;
   localparam logic [1:0] REG_INV = 2'd3;

   localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(2**RAM_AW);
   localparam logic [ADDR_W:0] SCR_END = (ADDR_W+1)'(2**RAM_AW + 2**SCR_AW);
   localparam int              DEPTH   = 2**FIFO_AW;

   logic [DATA_W-1:0] ram_q [2**RAM_AW];
   logic [DATA_W-1:0] scr_q [2**SCR_AW];
   logic [SCR_AW-1:0] fifo_addr_q [DEPTH];
   logic [DATA_W-1:0] fifo_data_q [DEPTH];

   logic [DATA_W-1:0] ram_rd_q, scr_rd_q, kbd_rd_q;
   logic [DATA_W-1:0] kbd_q, kbd_d;
   logic [1:0]        region_q, region_d;
   logic              rd_vld_q;
   logic              fault_q, fault_d;
   logic              ovf_q, ovf_d;
   logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SCR_AW-1:0] scr_off;
   logic              fault_ev, push_req, push_ok, pop, full, empty, ovf_ev;

   always_comb begin
      region_d = REG_INV;
      if ({1'b0, address_i} < RAM_END)
         region_d = REG_RAM;
      else if ({1'b0, address_i} < SCR_END)
         region_d = REG_SCR;
      else if (address_i == KBD_ADDR)
         region_d = REG_KBD;
   end

   assign scr_off  = SCR_AW'(address_i - RAM_END[ADDR_W-1:0]);
   assign fault_ev = (region_d == REG_INV) || (region_d == REG_KBD && load_i);

   // Extra pointer bit distinguishes full from empty when the low bits match.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign pop      = !empty && scr_ready_i;
   assign push_req = load_i && (region_d == REG_SCR);
   assign push_ok  = push_req && (!full || pop);
   assign ovf_ev   = push_req && full && !pop;

   always_comb begin
      kbd_d = kbd_q;
      if (kbd_strobe_i)
         kbd_d = kbd_code_i;
      else if (kbd_release_i)
         kbd_d = '0;
      fault_d  = fault_ev || (fault_q && !fault_clr_i);
      ovf_d    = ovf_ev || (ovf_q && !fault_clr_i);
      wr_ptr_d = push_ok ? wr_ptr_q + (FIFO_AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + (FIFO_AW+1)'(1) : rd_ptr_q;
   end

   // Storage arrays are deliberately left out of reset.
   always_ff @(posedge clk) begin
      ram_rd_q <= ram_q[address_i[RAM_AW-1:0]];
      scr_rd_q <= scr_q[scr_off];
      if (load_i && region_d == REG_RAM)
         ram_q[address_i[RAM_AW-1:0]] <= in_i;
      if (load_i && region_d == REG_SCR)
         scr_q[scr_off] <= in_i;
      if (push_ok) begin
         fifo_addr_q[wr_ptr_q[FIFO_AW-1:0]] <= scr_off;
         fifo_data_q[wr_ptr_q[FIFO_AW-1:0]] <= in_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         region_q <= REG_RAM;
         rd_vld_q <= 1'b0;
         kbd_q    <= '0;
         kbd_rd_q <= '0;
         fault_q  <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         region_q <= region_d;
         rd_vld_q <= 1'b1;
         kbd_q    <= kbd_d;
         kbd_rd_q <= kbd_q;
         fault_q  <= fault_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_comb begin
      out_o = '0;
      if (rd_vld_q) begin
         case (region_q)
            REG_RAM: out_o = ram_rd_q;
            REG_SCR: out_o = scr_rd_q;
            REG_KBD: out_o = kbd_rd_q;
            default: out_o = '0;
         endcase
      end
   end

   assign region_o    = region_q;
   assign fault_o     = fault_q;
   assign scr_ovf_o   = ovf_q;
   assign scr_valid_o = !empty;
   assign scr_addr_o  = fifo_addr_q[rd_ptr_q[FIFO_AW-1:0]];
   assign scr_data_o  = fifo_data_q[rd_ptr_q[FIFO_AW-1:0]];

`ifdef HACK_MEM_FAULT_CNT_EN
   logic [7:0] fault_cnt_q;

   // Clear and a coincident fault leave the count at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fault_cnt_q <= 8'd0;
      else if (fault_clr_i)
         fault_cnt_q <= fault_ev ? 8'd1 : 8'd0;
      else if (fault_ev && fault_cnt_q != 8'hFF)
         fault_cnt_q <= fault_cnt_q + 8'd1;
   end

   assign fault_cnt_o = fault_cnt_q;
`else
   assign fault_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_hack_mem_ctrl.sv
// tb/tb_hack_mem_ctrl.sv - directed self-checking bench for hack_mem_ctrl
module tb_hack_mem_ctrl;

`ifdef HACK_MEM_FAULT_CNT_EN
   localparam logic [7:0] CNT_ONE = 8'd1;
`else
   localparam logic [7:0] CNT_ONE = 8'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in_i = '0;
   logic [14:0] address_i = '0;
   logic        load_i = 1'b0;
   logic [15:0] out_o;
   logic [1:0]  region_o;
   logic        fault_o;
   logic        fault_clr_i = 1'b0;
   logic [15:0] kbd_code_i = '0;
   logic        kbd_strobe_i = 1'b0;
   logic        kbd_release_i = 1'b0;
   logic        scr_valid_o;
   logic        scr_ready_i = 1'b0;
   logic [12:0] scr_addr_o;
   logic [15:0] scr_data_o;
   logic        scr_ovf_o;
   logic [7:0]  fault_cnt_o;

   int total = 0;
   int bad = 0;

   hack_mem_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_i          (in_i),
      .address_i     (address_i),
      .load_i        (load_i),
      .out_o         (out_o),
      .region_o      (region_o),
      .fault_o       (fault_o),
      .fault_clr_i   (fault_clr_i),
      .kbd_code_i    (kbd_code_i),
      .kbd_strobe_i  (kbd_strobe_i),
      .kbd_release_i (kbd_release_i),
      .scr_valid_o   (scr_valid_o),
      .scr_ready_i   (scr_ready_i),
      .scr_addr_o    (scr_addr_o),
      .scr_data_o    (scr_data_o),
      .scr_ovf_o     (scr_ovf_o),
      .fault_cnt_o   (fault_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [14:0] a, input logic [15:0] d);
      address_i = a; in_i = d; load_i = 1'b1;
      tick();
      load_i = 1'b0;
   endtask

   task automatic rd(input logic [14:0] a);
      address_i = a; load_i = 1'b0;
      tick();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_out", out_o, 0);
      check("rst_region", region_o, 0);
      check("rst_fault", fault_o, 0);
      check("rst_ovf", scr_ovf_o, 0);
      check("rst_valid", scr_valid_o, 0);
      check("rst_cnt", fault_cnt_o, 0);
      rst_n = 1'b1;
      tick();

      // RAM write/read
      wr(15'h00FF, 16'h00FF);
      rd(15'h00FF);
      check("ram_out", out_o, 16'h00FF);
      check("ram_region", region_o, 0);
      check("ram_fault", fault_o, 0);
      wr(15'h3000, 16'h1234);
      address_i = 15'h3000; in_i = 16'h5555; load_i = 1'b1;
      tick();
      check("rbw_old", out_o, 16'h1234);
      wr(15'h3000, 16'h1234);

      // screen write and mirror
      wr(15'h50FF, 16'hFFFF);
      check("scr_region", region_o, 1);
      check("scr_valid1", scr_valid_o, 1);
      check("scr_addr", scr_addr_o, 13'h10FF);
      check("scr_data", scr_data_o, 16'hFFFF);
      scr_ready_i = 1'b1;
      rd(15'h50FF);
      check("scr_valid0", scr_valid_o, 0);
      check("scr_rd", out_o, 16'hFFFF);

      // keyboard
      kbd_code_i = 16'h0041; kbd_strobe_i = 1'b1;
      tick();
      kbd_strobe_i = 1'b0;
      rd(15'h6000);
      check("kbd_out", out_o, 16'h0041);
      check("kbd_region", region_o, 2);
      check("kbd_nofault", fault_o, 0);
      kbd_release_i = 1'b1;
      rd(15'h6000);
      check("kbd_pre_edge", out_o, 16'h0041);
      kbd_release_i = 1'b0;
      rd(15'h6000);
      check("kbd_released", out_o, 0);
      kbd_code_i = 16'h0042; kbd_strobe_i = 1'b1; kbd_release_i = 1'b1;
      tick();
      kbd_strobe_i = 1'b0; kbd_release_i = 1'b0;
      rd(15'h6000);
      check("kbd_both", out_o, 16'h0042);

      // invalid write fault
      wr(15'h7000, 16'hFF12);
      check("inv_region", region_o, 3);
      check("inv_out", out_o, 0);
      check("inv_fault", fault_o, 1);
      check("inv_cnt", fault_cnt_o, CNT_ONE);
      rd(15'h3000);
      check("inv_ram_kept", out_o, 16'h1234);
      check("fault_sticky", fault_o, 1);
      fault_clr_i = 1'b1;
      rd(15'h0000);
      fault_clr_i = 1'b0;
      check("clr_fault", fault_o, 0);
      check("clr_cnt", fault_cnt_o, 0);
      fault_clr_i = 1'b1;
      rd(15'h7FFF);
      fault_clr_i = 1'b0;
      check("set_wins", fault_o, 1);
      check("set_wins_cnt", fault_cnt_o, CNT_ONE);
      wr(15'h6000, 16'h0001);
      check("kbd_wr_fault", fault_o, 1);
      check("kbd_wr_cnt", fault_cnt_o, CNT_ONE << 1);
      fault_clr_i = 1'b1;
      rd(15'h0000);
      fault_clr_i = 1'b0;
      check("clr2", fault_o, 0);

      // overflow
      scr_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) wr(15'h4000 + 15'(i), 16'hA000 + 16'(i));
      check("four_no_ovf", scr_ovf_o, 0);
      wr(15'h4004, 16'hA004);
      check("ovf_set", scr_ovf_o, 1);
      rd(15'h4004);
      check("ovf_scr_written", out_o, 16'hA004);
      scr_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain_v%0d", i), scr_valid_o, 1);
         check($sformatf("drain_a%0d", i), scr_addr_o, i);
         check($sformatf("drain_d%0d", i), scr_data_o, 16'hA000 + 16'(i));
         tick();
      end
      check("drain_empty", scr_valid_o, 0);
      check("ovf_sticky", scr_ovf_o, 1);
      fault_clr_i = 1'b1;
      rd(15'h0000);
      fault_clr_i = 1'b0;
      check("ovf_clr", scr_ovf_o, 0);

      // full with simultaneous push and pop
      scr_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) wr(15'h4020 + 15'(i), 16'hC000 + 16'(i));
      scr_ready_i = 1'b1;
      wr(15'h4024, 16'hC004);
      check("pp_no_ovf", scr_ovf_o, 0);
      for (int i = 1; i < 5; i++) begin
         check($sformatf("pp_d%0d", i), scr_data_o, 16'hC000 + 16'(i));
         tick();
      end
      check("pp_empty", scr_valid_o, 0);

      // reset mid-drain
      scr_ready_i = 1'b0;
      wr(15'h4010, 16'hB000);
      wr(15'h4011, 16'hB001);
      scr_ready_i = 1'b1;
      rd(15'h00FF);
      check("mid_valid", scr_valid_o, 1);
      check("mid_out", out_o, 16'h00FF);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", scr_valid_o, 0);
      check("arst_out", out_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(15'h00FF);
      check("post_rst_ram", out_o, 16'h00FF);
      check("post_rst_valid", scr_valid_o, 0);
      rd(15'h3000);
      check("post_rst_ram2", out_o, 16'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
